// File: rtl/uart_out_tx.sv
// uart_out_tx: buffers 32-bit OUT words in a small FIFO and sends each one
// over a UART line as four 8N1 bytes, most significant byte first.
module uart_out_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_ADDR    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    output logic                  tx,
    output logic                  busy,
    output logic                  full,
    output logic [FIFO_ADDR:0]    count,
    output logic                  overflow
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]        BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]        TIMER_ONE = TW'(1);
    localparam logic [FIFO_ADDR:0]   DEPTH_CNT = (FIFO_ADDR + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_ADDR:0]   CNT_ONE   = (FIFO_ADDR + 1)'(1);
    localparam logic [FIFO_ADDR-1:0] PTR_ONE   = FIFO_ADDR'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                 state;
    logic                   write_d;
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FIFO_ADDR-1:0]   wr_ptr;
    logic [FIFO_ADDR-1:0]   rd_ptr;
    logic [DATA_WIDTH-1:0]  shift_word;
    logic [1:0]             byte_idx;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_next;
    logic [TW-1:0]          bit_timer;
    logic [7:0]             cur_byte;
    logic                   push_req;
    logic                   pop;
    logic                   push_ok;

    // A push is the rising edge of the level write request; a full FIFO
    // still accepts it when the LOAD pop frees a slot in the same cycle.
    assign push_req = write & ~write_d;
    assign pop      = (state == LOAD);
    assign push_ok  = push_req & (~full | pop);
    assign full     = (count == DEPTH_CNT);
    assign busy     = (state != IDLE) | (count != '0);
    assign bit_next = bit_idx + 3'd1;

    // Byte currently on the wire: byte 0 is the most significant byte.
    always_comb begin
        cur_byte = shift_word[31:24];
        case (byte_idx)
            2'd0:    cur_byte = shift_word[31:24];
            2'd1:    cur_byte = shift_word[23:16];
            2'd2:    cur_byte = shift_word[15:8];
            default: cur_byte = shift_word[7:0];
        endcase
    end

    // FIFO storage: plain array, written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    // Write edge detect, FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_d  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            write_d <= write;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Serializer FSM: tx is registered and set together with the next state,
    // so the line value always matches the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            shift_word <= '0;
            byte_idx   <= 2'd0;
            bit_idx    <= 3'd0;
            bit_timer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx        <= 1'b1;
                    bit_timer <= '0;
                    if (count != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shift_word <= fifo_mem[rd_ptr];
                    byte_idx   <= 2'd0;
                    bit_timer  <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_timer == BIT_LAST) begin
                        bit_timer <= '0;
                        bit_idx   <= 3'd0;
                        tx        <= cur_byte[0];
                        state     <= DATA;
                    end else begin
                        bit_timer <= bit_timer + TIMER_ONE;
                    end
                end
                DATA: begin
                    if (bit_timer == BIT_LAST) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_next;
                            tx      <= cur_byte[bit_next];
                        end
                    end else begin
                        bit_timer <= bit_timer + TIMER_ONE;
                    end
                end
                STOP: begin
                    if (bit_timer == BIT_LAST) begin
                        bit_timer <= '0;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else if (count != '0) begin
                            tx    <= 1'b1;
                            state <= LOAD;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer + TIMER_ONE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_out_tx.sv
// Bench for uart_out_tx: randomized and directed pushes, a timing-level
// reference model feeding a scoreboard queue, and a tx line decoder.
module tb_uart_out_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 40 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic        write = 1'b0;
    logic        tx;
    logic        busy;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    uart_out_tx #(
        .DATA_WIDTH  (32),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .FIFO_ADDR   (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .write   (write),
        .tx      (tx),
        .busy    (busy),
        .full    (full),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        int          pcyc;
    } mword_t;

    typedef struct {
        logic [31:0] word;
        int          start;
    } exp_t;

    mword_t mq[$];     // words accepted into the FIFO, not yet popped
    exp_t   exp_q[$];  // scoreboard: frames the line must carry, in order

    int checks = 0;
    int failures = 0;

    // Reference model state (timing rules expressed as cycle arithmetic).
    int next_free = 0;
    int last_load = 0;
    bit have_load = 0;
    bit prev_w = 0;
    bit m_ovf = 0;

    // Per-cycle expectations handed from the driver to the monitor.
    bit chk_valid = 0;
    int m_count = 0;
    bit m_busy = 0;
    bit m_ovf_snap = 0;

    // Line decoder state.
    bit          mon_active = 0;
    int          mon_start = 0;
    logic [31:0] mon_word = '0;
    int          frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of that cycle.
    task automatic do_cycle(input logic w, input logic [31:0] d);
        int  cpre;
        bit  pop;
        bit  push;
        write   = w;
        data_in = d;
        cpre = mq.size();
        pop  = (cpre > 0) && (cyc >= next_free) && (cyc >= mq[0].pcyc + 2);
        m_ovf_snap = m_ovf;
        if (pop) begin
            exp_q.push_back('{mq[0].word, cyc + 1});
            last_load = cyc;
            have_load = 1;
            next_free = cyc + FRAME + 1;
            void'(mq.pop_front());
        end
        push = w && !prev_w;
        prev_w = w;
        if (push) begin
            if (cpre < DEPTH || pop) mq.push_back('{d, cyc});
            else m_ovf = 1;
        end
        m_count = cpre;
        m_busy  = (cpre != 0) || (have_load && cyc >= last_load && cyc <= last_load + FRAME);
        chk_valid = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, $urandom);
    endtask

    // Asynchronous reset between clock edges, outputs checked before any edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        write = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        mq.delete();
        exp_q.delete();
        next_free = 0;
        have_load = 0;
        prev_w = 0;
        m_ovf = 0;
        chk_valid = 0;
        mon_active = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: per-cycle status compare and mid-bit decoding of tx frames.
    always @(negedge clk) begin
        int off;
        int k;
        int pos;
        int bi;
        exp_t e;
        if (reset) begin
            mon_active = 0;
        end else begin
            if (chk_valid) begin
                check("count", {29'd0, count}, m_count);
                check("full", {31'd0, full}, {31'd0, m_count == DEPTH});
                check("busy", {31'd0, busy}, {31'd0, m_busy});
                check("overflow", {31'd0, overflow}, {31'd0, m_ovf_snap});
            end
            if (!mon_active && tx == 1'b0) begin
                mon_active = 1;
                mon_start  = cyc;
                mon_word   = '0;
            end
            if (mon_active) begin
                off = cyc - mon_start;
                if (off % CPB == CPB / 2) begin
                    k   = off / CPB;
                    pos = k % 10;
                    bi  = k / 10;
                    if (pos == 0) check("start_bit", {31'd0, tx}, 32'd0);
                    else if (pos == 9) check("stop_bit", {31'd0, tx}, 32'd1);
                    else mon_word[(3 - bi) * 8 + (pos - 1)] = tx;
                    if (k == 39) begin
                        mon_active = 0;
                        frames++;
                        $display("frame %0d word=%08h start_cycle=%0d", frames, mon_word, mon_start);
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL frame_unexpected: got word %08h expected no frame", mon_word);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_word", mon_word, e.word);
                            check("frame_start", mon_start, e.start);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] w;
        // Power-on reset, checked without waiting for a clock edge.
        #1;
        reset = 1'b1;
        #1;
        check("por_tx", {31'd0, tx}, 32'd1);
        check("por_busy", {31'd0, busy}, 32'd0);
        check("por_count", {29'd0, count}, 32'd0);
        check("por_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        // Single word with write held high for 100 cycles.
        for (int i = 0; i < 100; i++) do_cycle(1'b1, (i == 0) ? 32'h1234_5678 : $urandom);
        idle(100);

        // Burst of six pulses two cycles apart; the sixth overflows.
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1, 32'hA0 + i);
            do_cycle(1'b0, $urandom);
        end
        idle(5 * (FRAME + 1) + 10);
        do_reset();

        // Full FIFO with a push landing on the LOAD cycle of the next word.
        for (int i = 0; i < 200; i++) begin
            if (i == 0 || i == 4 || i == 6 || i == 8 || i == 10 || i == FRAME + 3)
                do_cycle(1'b1, (i == FRAME + 3) ? 32'hC011_1DE0 : $urandom);
            else
                do_cycle(1'b0, $urandom);
        end
        idle(5 * (FRAME + 1));

        // Reset during data bit 3 of byte 1, with more words queued.
        for (int i = 0; i < 60; i++) begin
            if (i == 0 || i == 2 || i == 4) do_cycle(1'b1, $urandom);
            else do_cycle(1'b0, $urandom);
        end
        do_reset();
        do_cycle(1'b1, 32'hDEAD_BEEF);
        idle(FRAME + 10);

        // Ten spaced single pushes to walk the pointers around twice.
        for (int n = 0; n < 10; n++) begin
            do_cycle(1'b1, $urandom);
            idle(FRAME + 9);
        end

        // Random level activity on write with random data.
        for (int i = 0; i < 1500; i++) begin
            w = $urandom;
            do_cycle($urandom_range(0, 9) < 3, w);
        end

        // Drain: every expected frame must appear within a bounded time.
        guard = 0;
        while ((mq.size() != 0 || exp_q.size() != 0 || mon_active) && guard < 3000) begin
            do_cycle(1'b0, $urandom);
            guard++;
        end
        check("drain_timeout", guard < 3000, 32'd1);
        check("drain_pending", exp_q.size(), 32'd0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
